// File: rtl/video_sync_decoder.sv
// video_sync_decoder: recovers pixel x/y from hsync/vsync/rgb and checks raster timing.
// Define VIDEO_DECODER_CRC_EN to add a per-frame CRC-16-CCITT of active pixels on frame_crc.
module video_sync_decoder #(
  parameter int unsigned H_TOTAL  = 309,
  parameter int unsigned V_TOTAL  = 262,
  parameter int unsigned H_START  = 46,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_START  = 8,
  parameter int unsigned V_ACTIVE = 240,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        locked,
  output logic        pixel_valid,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        frame_done,
  output logic [16:0] lit_count,
  output logic [9:0]  line_len,
  output logic [8:0]  frame_lines,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] HT      = 10'(H_TOTAL);
  localparam logic [9:0] HA_MIN  = 10'(H_START);
  localparam logic [9:0] HA_MAX  = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] TIMEOUT = 10'(2 * H_TOTAL - 1);
  localparam logic [8:0] VT      = 9'(V_TOTAL);
  localparam logic [8:0] VA_MIN  = 9'(V_START);
  localparam logic [8:0] VA_MAX  = 9'(V_START + V_ACTIVE - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_act_q, hs_prev_q, vs_act_q, vs_prev_q;
  logic [2:0]  rgb_q;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [8:0]  v_cnt_q, v_cnt_d;
  logic        bad_q, bad_d;
  logic [16:0] acc_q, acc_d;
  logic        pv_q, pv_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        frame_done_q;
  logic [16:0] lit_q, lit_d;
  logic [9:0]  line_len_q, line_len_d;
  logic [8:0]  frame_lines_q, frame_lines_d;
  logic [7:0]  err_q, err_d;

  logic        h_edge, v_edge, line_bad, frame_bad, timeout, err_inc, lit_inc;
  logic [9:0]  len_meas;
  logic [8:0]  lines_meas;

  always_comb begin
    h_edge     = hs_act_q & ~hs_prev_q;
    v_edge     = vs_act_q & ~vs_prev_q;
    len_meas   = (h_cnt_q == 10'h3FF) ? 10'h3FF : h_cnt_q + 10'd1;
    lines_meas = (v_cnt_q == 9'h1FF) ? 9'h1FF : v_cnt_q + 9'd1;
    line_bad   = h_edge && (len_meas != HT);
    frame_bad  = v_edge && (lines_meas != VT);
    timeout    = !h_edge && (h_cnt_q == TIMEOUT);

    h_cnt_d = h_edge ? '0 : len_meas;
    if (v_edge)
      v_cnt_d = '0;
    else if (h_edge)
      v_cnt_d = lines_meas;
    else
      v_cnt_d = v_cnt_q;
    line_len_d    = h_edge ? len_meas : line_len_q;
    frame_lines_d = v_edge ? lines_meas : frame_lines_q;

    // A MEASURE window opens on a vsync edge; the line closed by that same edge
    // belongs to the previous (unqualified) frame, so it is not held against lock.
    state_d = state_q;
    bad_d   = bad_q;
    err_inc = 1'b0;
    case (state_q)
      SEARCH: begin
        if (v_edge) begin
          state_d = MEASURE;
          bad_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (v_edge) begin
          bad_d = 1'b0;
          if (!bad_q && !line_bad && !frame_bad)
            state_d = LOCKED;
        end else if (line_bad) begin
          bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          err_inc = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (timeout) begin
      state_d = SEARCH;
      if (state_q == LOCKED)
        err_inc = 1'b1;
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    pv_d = (state_d == LOCKED) &&
           (h_cnt_d >= HA_MIN) && (h_cnt_d <= HA_MAX) &&
           (v_cnt_d >= VA_MIN) && (v_cnt_d <= VA_MAX);
    x_d  = pv_d ? 9'(h_cnt_d - HA_MIN) : x_q;
    y_d  = pv_d ? 8'(v_cnt_d - VA_MIN) : y_q;

    lit_inc = pv_d && (rgb_q != 3'b000);
    acc_d   = v_edge ? '0 : acc_q + 17'(lit_inc);
    lit_d   = (v_edge && state_q == LOCKED) ? acc_q + 17'(lit_inc) : lit_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      hs_act_q      <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_act_q      <= 1'b0;
      vs_prev_q     <= 1'b0;
      rgb_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bad_q         <= 1'b0;
      acc_q         <= '0;
      pv_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_done_q  <= 1'b0;
      lit_q         <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      hs_act_q      <= (hsync == SYNC_POL);
      hs_prev_q     <= hs_act_q;
      vs_act_q      <= (vsync == SYNC_POL);
      vs_prev_q     <= vs_act_q;
      rgb_q         <= rgb;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bad_q         <= bad_d;
      acc_q         <= acc_d;
      pv_q          <= pv_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_done_q  <= v_edge;
      lit_q         <= lit_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign pixel_valid = pv_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_done  = frame_done_q;
  assign lit_count   = lit_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_q;

`ifdef VIDEO_DECODER_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [7:0]  b;
    r = c;
    b = d;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ b[7])
        r = {r[14:0], 1'b0} ^ 16'h1021;
      else
        r = {r[14:0], 1'b0};
      b = {b[6:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc_q, crc_d, crc_upd, fcrc_q, fcrc_d;

  always_comb begin
    crc_upd = pv_d ? crc16_byte(crc_q, {5'b00000, rgb_q}) : crc_q;
    crc_d   = v_edge ? 16'hFFFF : crc_upd;
    fcrc_d  = (v_edge && state_q == LOCKED) ? crc_upd : fcrc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
    end
  end

  assign frame_crc = fcrc_q;
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder on a reduced raster; per-frame expectations
// are queued as each frame is driven and checked on every frame_done pulse.
module tb_video_sync_decoder;
  localparam int HT = 64;
  localparam int VT = 32;
  localparam int HS = 10;
  localparam int HA = 48;
  localparam int VS = 4;
  localparam int VA = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [2:0]  rgb;
  logic        locked, pixel_valid, frame_done;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [16:0] lit_count;
  logic [9:0]  line_len;
  logic [8:0]  frame_lines;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  video_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACTIVE(HA),
    .V_START(VS), .V_ACTIVE(VA), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_done(frame_done), .lit_count(lit_count), .line_len(line_len),
    .frame_lines(frame_lines), .err_count(err_count), .frame_crc(frame_crc)
  );

  typedef struct {
    string       tag;
    bit          lk;
    int          err;
    bit          geom;
    int          len;
    int          lines;
    int          lit;
    logic [15:0] crc;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   fails  = 0;
  int   total  = 0;
  bit   pv_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 0 black, 1 white, 2 single lit pixel at (0,0), 3 diagonal pattern
  function automatic logic [2:0] pix(input int mode, input int px, input int py);
    case (mode)
      1:       return 3'b111;
      2:       return (px == 0 && py == 0) ? 3'b001 : 3'b000;
      3:       return 3'((px ^ py) & 7);
      default: return 3'b000;
    endcase
  endfunction

  function automatic int lit_model(input int mode);
    int n = 0;
    for (int py = 0; py < VA; py++)
      for (int px = 0; px < HA; px++)
        if (pix(mode, px, py) != 3'b000) n++;
    return n;
  endfunction

  function automatic logic [15:0] crc_model(input int mode);
`ifdef VIDEO_DECODER_CRC_EN
    logic [15:0] c = 16'hFFFF;
    logic [7:0]  b;
    for (int py = 0; py < VA; py++)
      for (int px = 0; px < HA; px++) begin
        b = {5'b00000, pix(mode, px, py)};
        for (int i = 0; i < 8; i++) begin
          c = (c[15] ^ b[7]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
          b = {b[6:0], 1'b0};
        end
      end
    return c;
`else
    return (mode < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic push(input string tag, input bit lk, input int err, input bit geom,
                      input int len, input int lines, input int lit, input logic [15:0] crc);
    exp_t e;
    e.tag = tag; e.lk = lk; e.err = err; e.geom = geom;
    e.len = len; e.lines = lines; e.lit = lit; e.crc = crc;
    sb.push_back(e);
  endtask

  task automatic drive_lines(input int mode, input int l0, input int l1, input int long_line);
    int len;
    for (int l = l0; l <= l1; l++) begin
      len = (l == long_line) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        hsync = (c < 6);
        vsync = (l < 2);
        rgb   = (c >= HS && c < HS + HA && l >= VS && l < VS + VA) ? pix(mode, c - HS, l - VS) : 3'b000;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hsync = 1'b0;
      vsync = 1'b0;
      rgb   = 3'b000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_lit_count"}, 32'(lit_count), 0);
    chk({tag, "_line_len"}, 32'(line_len), 0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_frame_crc"}, 32'(frame_crc), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && frame_done === 1'b1) begin
      chk("frame_done_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_locked"}, 32'(locked), 32'(e.lk));
        chk({e.tag, "_err_count"}, 32'(err_count), 32'(e.err));
        chk({e.tag, "_lit_count"}, 32'(lit_count), 32'(e.lit));
        chk({e.tag, "_frame_crc"}, 32'(frame_crc), 32'(e.crc));
        if (e.geom) begin
          chk({e.tag, "_line_len"}, 32'(line_len), 32'(e.len));
          chk({e.tag, "_frame_lines"}, 32'(frame_lines), 32'(e.lines));
        end
      end
    end
    if (pixel_valid === 1'b1 && !pv_seen) begin
      pv_seen = 1'b1;
      chk("first_pixel_x", 32'(x), 0);
      chk("first_pixel_y", 32'(y), 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: stimulus did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lit_w, lit_p, lit_s;
    logic [15:0] crc_w, crc_p, crc_s;
    lit_w = lit_model(1); lit_p = lit_model(3); lit_s = lit_model(2);
    crc_w = crc_model(1); crc_p = crc_model(3); crc_s = crc_model(2);

    reset = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = 3'b000;
    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;

    push("e1_search", 0, 0, 0, 0, 0, 0, 16'h0000);
    drive_lines(1, 0, 15, -1);
    chk("f0_mid_locked", 32'(locked), 0);
    drive_lines(1, 16, VT - 1, -1);

    push("e2_lock", 1, 0, 1, HT, VT, 0, 16'h0000);
    drive_lines(1, 0, VT - 1, -1);
    push("e3_white", 1, 0, 1, HT, VT, lit_w, crc_w);
    drive_lines(3, 0, VT - 1, -1);
    push("e4_pattern", 1, 0, 1, HT, VT, lit_p, crc_p);
    drive_lines(2, 0, VT - 1, -1);
    push("e5_single", 1, 0, 1, HT, VT, lit_s, crc_s);

    drive_lines(1, 0, 8, 5);
    chk("longline_locked", 32'(locked), 0);
    chk("longline_err", 32'(err_count), 1);
    drive_lines(1, 9, VT - 1, -1);
    push("e6_after_err", 0, 1, 1, HT, VT, lit_s, crc_s);
    drive_lines(1, 0, VT - 1, -1);
    push("e7_relock", 1, 1, 1, HT, VT, lit_s, crc_s);

    drive_lines(3, 0, 15, -1);
    idle(700);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_err", 32'(err_count), 2);
    push("e8_after_timeout", 0, 2, 1, HT + 700, 16, lit_s, crc_s);
    drive_lines(1, 0, VT - 1, -1);
    push("e9_relock", 1, 2, 1, HT, VT, lit_s, crc_s);

    drive_lines(1, 0, 10, -1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(5);
    reset = 1'b1;

    push("e10_search", 0, 0, 0, 0, 0, 0, 16'h0000);
    drive_lines(3, 0, VT - 1, -1);
    push("e11_lock", 1, 0, 1, HT, VT, 0, 16'h0000);
    drive_lines(2, 0, VT - 1, -1);
    push("e12_single", 1, 0, 1, HT, VT, lit_s, crc_s);
    drive_lines(0, 0, 1, -1);
    idle(4);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
